// File: rtl/ysyx_23060191_ifu_fetch.sv
// ysyx_23060191_ifu_fetch: multicycle instruction fetch, one instruction in flight, handing words to decode
module ysyx_23060191_ifu_fetch #(
    parameter int CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [CPU_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_resp_valid,
    input  logic [CPU_WIDTH-1:0] imem_resp_data,
    input  logic                 imem_resp_err,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [CPU_WIDTH-1:0] inst,
    output logic [CPU_WIDTH-1:0] inst_pc,
    input  logic                 npc_valid,
    input  logic [CPU_WIDTH-1:0] npc,
    output logic                 fetch_err,
    output logic [CPU_WIDTH-1:0] fetch_cnt
);
    typedef enum logic [2:0] {RESET_WAIT, REQ, RESP, DELIVER, NEXT, ERR} state_t;
    state_t state, state_nxt;
    logic [CPU_WIDTH-1:0] pc;
    always_comb begin
        state_nxt = state;
        case (state)
            RESET_WAIT: state_nxt = REQ;
            REQ:        state_nxt = imem_req_ready ? RESP : REQ;
            RESP:       state_nxt = imem_resp_valid ? (imem_resp_err ? ERR : DELIVER) : RESP;
            DELIVER:    state_nxt = inst_ready ? NEXT : DELIVER;
            NEXT:       state_nxt = npc_valid ? ((npc[1:0] != 2'b00) ? ERR : REQ) : NEXT;
            default:    state_nxt = ERR;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RESET_WAIT;
            pc        <= RESET_PC;
            inst      <= '0;
            inst_pc   <= '0;
            fetch_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == RESP && imem_resp_valid && !imem_resp_err) begin
                inst    <= imem_resp_data;
                inst_pc <= pc;
            end
            if (state == DELIVER && inst_ready)
                fetch_cnt <= fetch_cnt + CPU_WIDTH'(1);
            // a misaligned redirect goes to ERR and leaves pc untouched
            if (state == NEXT && npc_valid && npc[1:0] == 2'b00)
                pc <= npc;
        end
    end
    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == DELIVER);
    assign fetch_err      = (state == ERR);
endmodule

// File: tb/tb_ysyx_23060191_ifu_fetch.sv
// tb_ysyx_23060191_ifu_fetch: directed plan scenarios plus random traffic against a transaction-level model
module tb_ysyx_23060191_ifu_fetch;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int W_BOOT = 0, W_ACCEPT = 1, W_RESP = 2, W_TAKE = 3, W_NPC = 4, W_DEAD = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0, imem_resp_err = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst, inst_pc;
    logic        npc_valid = 1'b0;
    logic [31:0] npc = '0;
    logic        fetch_err;
    logic [31:0] fetch_cnt;

    int errors = 0, checks = 0;
    int m_wait = W_BOOT;
    logic [31:0] m_pc = RST_PC, m_inst = '0, m_ipc = '0, m_cnt = '0;
    int dead_cycles = 0;

    ysyx_23060191_ifu_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .npc_valid(npc_valid), .npc(npc), .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // What the fetch unit is waiting for, advanced by the handshakes seen at each edge
    task automatic model_edge();
        if (!rst_n) begin
            m_wait = W_BOOT; m_pc = RST_PC; m_inst = '0; m_ipc = '0; m_cnt = '0;
        end else if (m_wait == W_BOOT) m_wait = W_ACCEPT;
        else if (m_wait == W_ACCEPT && imem_req_ready) m_wait = W_RESP;
        else if (m_wait == W_RESP && imem_resp_valid) begin
            if (imem_resp_err) m_wait = W_DEAD;
            else begin m_inst = imem_resp_data; m_ipc = m_pc; m_wait = W_TAKE; end
        end else if (m_wait == W_TAKE && inst_ready) begin
            m_cnt = m_cnt + 1; m_wait = W_NPC;
        end else if (m_wait == W_NPC && npc_valid) begin
            if (npc % 4 != 0) m_wait = W_DEAD;
            else begin m_pc = npc; m_wait = W_ACCEPT; end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("req_valid", 32'(imem_req_valid), 32'(m_wait == W_ACCEPT));
        check("req_addr", imem_req_addr, m_pc);
        check("inst_valid", 32'(inst_valid), 32'(m_wait == W_TAKE));
        check("inst", inst, m_inst);
        check("inst_pc", inst_pc, m_ipc);
        check("fetch_err", 32'(fetch_err), 32'(m_wait == W_DEAD));
        check("fetch_cnt", fetch_cnt, m_cnt);
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
        inst_ready = 1'b0; npc_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset release and first fetch
        idle_inputs();
        imem_req_ready = 1'b1;
        do_reset(3);
        check("lit_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("lit_rst_addr", imem_req_addr, 32'h8000_0000);
        check("lit_rst_inst", inst, 32'd0);
        check("lit_rst_cnt", fetch_cnt, 32'd0);
        cycle();
        check("lit_first_req", 32'(imem_req_valid), 32'd1);
        check("lit_first_addr", imem_req_addr, 32'h8000_0000);
        cycle();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
        cycle();
        imem_resp_valid = 1'b0;
        check("lit_inst_valid", 32'(inst_valid), 32'd1);
        check("lit_inst", inst, 32'h0000_0013);
        check("lit_inst_pc", inst_pc, 32'h8000_0000);
        // Handshake with a stray npc pulse in DELIVER, then redirect
        inst_ready = 1'b1; npc_valid = 1'b1; npc = 32'h8000_0040;
        cycle();
        check("lit_cnt1", fetch_cnt, 32'd1);
        inst_ready = 1'b0; npc = 32'h8000_0010;
        cycle();
        check("lit_redirect_addr", imem_req_addr, 32'h8000_0010);
        // Request backpressure with an ignored npc pulse
        npc = 32'h1234_5678; imem_req_ready = 1'b0;
        repeat (5) cycle();
        check("lit_held_addr", imem_req_addr, 32'h8000_0010);
        npc_valid = 1'b0; imem_req_ready = 1'b1;
        cycle();
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h00a0_0093;
        cycle();
        imem_resp_valid = 1'b0;
        repeat (4) cycle();
        check("lit_bp_inst_pc", inst_pc, 32'h8000_0010);
        check("lit_bp_cnt", fetch_cnt, 32'd1);
        inst_ready = 1'b1;
        cycle();
        check("lit_cnt2", fetch_cnt, 32'd2);
        // Misaligned redirect
        inst_ready = 1'b0; npc_valid = 1'b1; npc = 32'h8000_0002;
        cycle();
        check("lit_misalign_err", 32'(fetch_err), 32'd1);
        npc = 32'h8000_0100; imem_req_ready = 1'b1; imem_resp_valid = 1'b1; inst_ready = 1'b1;
        repeat (4) cycle();
        check("lit_err_sticky", 32'(fetch_err), 32'd1);
        check("lit_err_pc", imem_req_addr, 32'h8000_0010);
        // Bus error
        idle_inputs(); imem_req_ready = 1'b1;
        do_reset(1);
        cycle(); cycle();
        imem_resp_valid = 1'b1; imem_resp_err = 1'b1;
        cycle();
        idle_inputs();
        check("lit_buserr", 32'(fetch_err), 32'd1);
        check("lit_buserr_nv", 32'(inst_valid), 32'd0);
        // Reset while waiting for a response; the stale response lands after release
        imem_req_ready = 1'b1;
        do_reset(1);
        cycle(); cycle();
        imem_req_ready = 1'b0;
        do_reset(1);
        imem_resp_valid = 1'b1; imem_resp_data = 32'hbad0_0bad;
        cycle();
        imem_resp_valid = 1'b0;
        check("lit_stale_req", 32'(imem_req_valid), 32'd1);
        check("lit_stale_addr", imem_req_addr, 32'h8000_0000);
        check("lit_stale_cnt", fetch_cnt, 32'd0);
        check("lit_stale_err", 32'(fetch_err), 32'd0);
        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            dead_cycles = (m_wait == W_DEAD) ? dead_cycles + 1 : 0;
            rst_n = !($urandom_range(0, 299) == 0 || dead_cycles > 12);
            imem_req_ready = $urandom_range(0, 1) == 1;
            imem_resp_valid = $urandom_range(0, 1) == 1;
            imem_resp_err = $urandom_range(0, 39) == 0;
            imem_resp_data = $urandom;
            inst_ready = $urandom_range(0, 1) == 1;
            npc_valid = $urandom_range(0, 1) == 1;
            npc = ($urandom & 32'hffff_fffc) | (($urandom_range(0, 19) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_23060191_ifu_fetch.md
# ysyx_23060191_ifu_fetch

Instruction fetch stage of the NPC core, directly upstream of the decode unit. Holds the architectural PC, issues one instruction-memory read per instruction over a request/response handshake, and presents the fetched 32-bit word plus its PC to decode under a valid/ready handshake. After decode accepts, it waits for the next-PC redirect from the PC unit, then fetches again. This is a multicycle, one-instruction-in-flight design.

## Interface
Parameters:
- CPU_WIDTH, 32, data/address width
- RESET_PC, 32'h8000_0000, PC value loaded on reset

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- imem_req_valid  out  1  fetch request to instruction memory
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  CPU_WIDTH  fetch address (= pc)
- imem_resp_valid  in  1  read data valid
- imem_resp_data  in  CPU_WIDTH  fetched instruction word
- imem_resp_err  in  1  bus error on this response
- inst_valid  out  1  inst/inst_pc valid to decode
- inst_ready  in  1  decode consumes instruction
- inst  out  CPU_WIDTH  instruction to decode
- inst_pc  out  CPU_WIDTH  PC of inst
- npc_valid  in  1  next-PC strobe from PC unit
- npc  in  CPU_WIDTH  next PC value
- fetch_err  out  1  sticky error (bus error or misaligned npc)
- fetch_cnt  out  CPU_WIDTH  count of instructions delivered to decode

## Operation
- State machine: RESET_WAIT, REQ, RESP, DELIVER, NEXT, ERR.
- RESET_WAIT: entered while rst_n=0; pc=RESET_PC, all outputs 0 except imem_req_addr=RESET_PC. First cycle with rst_n=1 -> REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready=1 -> RESP. Address held stable until accepted.
- RESP: imem_req_valid=0. On imem_resp_valid=1: if imem_resp_err=1 -> ERR; else latch imem_resp_data into inst register -> DELIVER.
- DELIVER: inst_valid=1; inst and inst_pc stable until handshake. On inst_ready=1 -> NEXT, fetch_cnt += 1 (wraps 2^32-1 -> 0).
- NEXT: inst_valid=0; inst/inst_pc retain last values. On npc_valid=1: if npc[1:0]!=0 -> ERR (pc unchanged); else pc<=npc -> REQ.
- ERR: terminal until reset; fetch_err=1, imem_req_valid=0, inst_valid=0. All inputs ignored.
- npc_valid outside NEXT is ignored (no buffering). imem_resp_valid outside RESP is ignored.
- Reset mid-operation (any state, rst_n=0 sampled on edge): state->RESET_WAIT, pc=RESET_PC, fetch_err=0, fetch_cnt=0, inst=0, inst_pc=0; any outstanding memory response is dropped.

## Timing
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_err=0, fetch_cnt=0.
- All outputs registered or decoded from state register only; no combinational path from any input to any output.
- Minimum fetch latency: request issued cycle N, accepted N (ready=1), response at N+1 -> inst_valid asserted N+2.
- Response may arrive no earlier than the cycle after request acceptance; same-cycle response not supported.
- Delivery to redirect: inst_ready at cycle M -> NEXT at M+1; npc_valid at M+1 -> imem_req_valid at M+2 with new address.
- Steady-state throughput with zero-wait memory and immediate ready/npc: one instruction per 4 cycles.
- fetch_cnt updates the cycle after the inst handshake.

## Test plan
- Reset release: rst_n low 3 cycles, then high; memory always ready, responds 0x00000013 one cycle later -> imem_req_addr=0x80000000 at first REQ, inst_valid=1 with inst=0x00000013, inst_pc=0x80000000 two cycles after acceptance.
- Backpressure: imem_req_ready low 5 cycles, inst_ready low 4 cycles -> request and inst/inst_pc held stable throughout; exactly one request accepted; fetch_cnt increments by 1 only after ready.
- Redirect sequence: deliver at 0x80000000, npc=0x80000010 -> next request address 0x80000010, inst_pc=0x80000010; npc_valid pulses in REQ/DELIVER ignored.
- Misaligned npc: npc=0x80000002 -> fetch_err=1 next cycle, no further imem_req_valid, pc not updated, persists until reset.
- Bus error: imem_resp_err=1 with resp_valid -> fetch_err=1, inst_valid never asserted for that fetch.
- Mid-fetch reset: assert rst_n=0 while in RESP, then deliver stale response after release -> stale response ignored, fresh request to 0x80000000, fetch_cnt=0, fetch_err=0.
